// File: rtl/env_scan_feeder.sv
// Raster-order producer for the environment neighbourhood shift-cache: reads one
// location per step, pulses newLocClock per shift and tracks the centred location.
module env_scan_feeder #(
    parameter int PIXELS_X    = 640,
    parameter int PIXELS_Y    = 480,
    parameter int SIGNAL_bits = 6,
    parameter int X_bits      = 10,
    parameter int Y_bits      = 9,
    parameter int ADDR_bits   = 19
) (
    input  logic                   Clk,
    input  logic                   RESET_SIM,
    input  logic                   RUN,
    input  logic                   frame_start,
    output logic                   mem_rd,
    output logic [ADDR_bits-1:0]   mem_addr,
    input  logic                   mem_rvalid,
    input  logic [SIGNAL_bits-1:0] mem_rdata_signal,
    input  logic                   mem_rdata_sugar,
    output logic [SIGNAL_bits-1:0] viewSignal,
    output logic                   viewSugar,
    output logic                   newLocClock,
    output logic [X_bits-1:0]      writeLoc_X,
    output logic [Y_bits-1:0]      writeLoc_Y,
    output logic                   writeLoc_valid,
    output logic                   busy,
    output logic                   frame_done,
    output logic [2:0]             dbg_state
);

    localparam int CNT_bits = ADDR_bits + 1;
    localparam logic [CNT_bits-1:0] N_C     = CNT_bits'(PIXELS_X * PIXELS_Y);
    localparam logic [CNT_bits-1:0] LAG1_C  = CNT_bits'(PIXELS_X + 3);
    localparam logic [CNT_bits-1:0] TOTAL_C = CNT_bits'(PIXELS_X * PIXELS_Y + PIXELS_X + 2);
    localparam logic [X_bits-1:0]   X_MAX   = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0]   Y_MAX   = Y_bits'(PIXELS_Y - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EMIT  = 3'd2,
        FLUSH = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [X_bits-1:0]   rx;
    logic [Y_bits-1:0]   ry;
    logic [CNT_bits-1:0] rd_cnt;
    logic [CNT_bits-1:0] s;
    logic                flush_primed;

    logic [CNT_bits-1:0] s_inc;
    logic [X_bits-1:0]   wx_n;
    logic [Y_bits-1:0]   wy_n;
    logic                wv_n;

    // Memory handshake: mem_rd rises with a stable mem_addr and stays high until a
    // cycle with mem_rvalid=1, which both accepts the request and delivers the data.
    assign mem_addr  = ADDR_bits'(ry) * ADDR_bits'(PIXELS_X) + ADDR_bits'(rx);
    assign dbg_state = state;

    // Centre location after the next shift; it trails the read position by LAG shifts.
    always_comb begin
        s_inc = (s == TOTAL_C) ? s : s + 1'b1;
        wx_n  = writeLoc_X;
        wy_n  = writeLoc_Y;
        wv_n  = writeLoc_valid;
        if (s_inc == LAG1_C) begin
            wx_n = '0;
            wy_n = '0;
            wv_n = 1'b1;
        end else if (s_inc > LAG1_C) begin
            wv_n = 1'b1;
            if (writeLoc_X == X_MAX) begin
                wx_n = '0;
                if (writeLoc_Y != Y_MAX) wy_n = writeLoc_Y + 1'b1;
            end else begin
                wx_n = writeLoc_X + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state          <= IDLE;
            rx             <= '0;
            ry             <= '0;
            rd_cnt         <= '0;
            s              <= '0;
            flush_primed   <= 1'b0;
            mem_rd         <= 1'b0;
            viewSignal     <= '0;
            viewSugar      <= 1'b0;
            newLocClock    <= 1'b0;
            writeLoc_X     <= '0;
            writeLoc_Y     <= '0;
            writeLoc_valid <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            newLocClock <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start && RUN) begin
                        rx           <= '0;
                        ry           <= '0;
                        rd_cnt       <= '0;
                        s            <= '0;
                        flush_primed <= 1'b0;
                        busy         <= 1'b1;
                        mem_rd       <= 1'b1;
                        state        <= READ;
                    end
                end
                READ: begin
                    // A pending read is allowed to complete even while paused.
                    if (mem_rvalid) begin
                        viewSignal <= mem_rdata_signal;
                        viewSugar  <= mem_rdata_sugar;
                        mem_rd     <= 1'b0;
                        if (rd_cnt != N_C) rd_cnt <= rd_cnt + 1'b1;
                        if (rx == X_MAX) begin
                            rx <= '0;
                            if (ry != Y_MAX) ry <= ry + 1'b1;
                        end else begin
                            rx <= rx + 1'b1;
                        end
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (RUN) begin
                        newLocClock    <= 1'b1;
                        s              <= s_inc;
                        writeLoc_X     <= wx_n;
                        writeLoc_Y     <= wy_n;
                        writeLoc_valid <= wv_n;
                        if (rd_cnt < N_C) begin
                            mem_rd <= 1'b1;
                            state  <= READ;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // First visit only zeroes the data; the last real pulse is still high.
                    if (!flush_primed) begin
                        viewSignal   <= '0;
                        viewSugar    <= 1'b0;
                        flush_primed <= 1'b1;
                    end else if (RUN) begin
                        newLocClock    <= 1'b1;
                        s              <= s_inc;
                        writeLoc_X     <= wx_n;
                        writeLoc_Y     <= wy_n;
                        writeLoc_valid <= wv_n;
                        state          <= GAP;
                    end
                end
                GAP: begin
                    if (s == TOTAL_C) begin
                        frame_done     <= 1'b1;
                        busy           <= 1'b0;
                        writeLoc_valid <= 1'b0;
                        state          <= DONE;
                    end else begin
                        state <= FLUSH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_env_scan_feeder.sv
// Directed bench for env_scan_feeder on a 4x3 environment (N=12, LAG=6, 18 shifts).
module tb_env_scan_feeder;

    logic        clk;
    logic        RESET_SIM;
    logic        RUN;
    logic        frame_start;
    logic        mem_rd;
    logic [18:0] mem_addr;
    logic        mem_rvalid;
    logic [5:0]  mem_rdata_signal;
    logic        mem_rdata_sugar;
    logic [5:0]  viewSignal;
    logic        viewSugar;
    logic        newLocClock;
    logic [9:0]  writeLoc_X;
    logic [8:0]  writeLoc_Y;
    logic        writeLoc_valid;
    logic        busy;
    logic        frame_done;
    logic [2:0]  dbg_state;

    env_scan_feeder #(
        .PIXELS_X(4), .PIXELS_Y(3), .SIGNAL_bits(6),
        .X_bits(10), .Y_bits(9), .ADDR_bits(19)
    ) dut (
        .Clk(clk), .RESET_SIM(RESET_SIM), .RUN(RUN), .frame_start(frame_start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
        .mem_rdata_signal(mem_rdata_signal), .mem_rdata_sugar(mem_rdata_sugar),
        .viewSignal(viewSignal), .viewSugar(viewSugar), .newLocClock(newLocClock),
        .writeLoc_X(writeLoc_X), .writeLoc_Y(writeLoc_Y), .writeLoc_valid(writeLoc_valid),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents (nonzero signals so flush zeros are distinguishable)
    logic [5:0] mem_sig [12] = '{6'd5, 6'd12, 6'd33, 6'd7, 6'd63, 6'd1,
                                 6'd20, 6'd44, 6'd9, 6'd17, 6'd58, 6'd30};
    logic       mem_sug [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    int   checks = 0;
    int   errors = 0;
    bit   lat_rand = 0;

    // Memory responder state and logs
    int          wait_left = 0;
    bit          pending = 0;
    logic [18:0] held_addr = '0;
    int          unstable = 0;
    int          acc_addr[$];

    always @(negedge clk) begin
        if (RESET_SIM) begin
            mem_rvalid = 1'b0;
            wait_left  = 0;
            pending    = 0;
        end else begin
            if (pending && (!mem_rd || mem_addr != held_addr)) unstable++;
            mem_rvalid = 1'b0;
            pending    = 0;
            if (mem_rd) begin
                if (wait_left == 0) begin
                    mem_rvalid       = 1'b1;
                    mem_rdata_signal = (mem_addr < 12) ? mem_sig[mem_addr] : 6'd0;
                    mem_rdata_sugar  = (mem_addr < 12) ? mem_sug[mem_addr] : 1'b0;
                    acc_addr.push_back(int'(mem_addr));
                    wait_left = lat_rand ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    wait_left--;
                    pending   = 1;
                    held_addr = mem_addr;
                end
            end
        end
    end

    // Pulse monitor
    logic [5:0] p_view[$];
    logic       p_sug[$];
    logic [9:0] p_wx[$];
    logic [8:0] p_wy[$];
    logic       p_wv[$];
    int         fd_log[$];
    bit         fd_prev[$];
    bit         prev_nl = 0;
    int         b2b = 0;

    always @(negedge clk) begin
        if (newLocClock) begin
            if (prev_nl) b2b++;
            p_view.push_back(viewSignal);
            p_sug.push_back(viewSugar);
            p_wx.push_back(writeLoc_X);
            p_wy.push_back(writeLoc_Y);
            p_wv.push_back(writeLoc_valid);
        end
        if (frame_done) begin
            fd_log.push_back(p_view.size());
            fd_prev.push_back(prev_nl);
        end
        prev_nl = newLocClock;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(output int pb, output int ab, output int fdb);
        pb  = p_view.size();
        ab  = acc_addr.size();
        fdb = fd_log.size();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int fdb);
        int n = 0;
        while (fd_log.size() == fdb && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", fd_log.size() > fdb, 1);
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", writeLoc_valid, 0);
        chk("hold_x_after_done", writeLoc_X, 3);
        chk("hold_y_after_done", writeLoc_Y, 2);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int pb, input int ab, input int fdb);
        chk("pulse_count", p_view.size() - pb, 18);
        chk("read_count", acc_addr.size() - ab, 12);
        for (int i = 0; i < 12; i++)
            if (ab + i < acc_addr.size()) chk("read_addr", acc_addr[ab + i], i);
        for (int k = 1; k <= 18; k++) begin
            if (pb + k - 1 < p_view.size()) begin
                int idx = pb + k - 1;
                chk("pulse_view", p_view[idx], (k <= 12) ? mem_sig[k - 1] : 6'd0);
                chk("pulse_sugar", p_sug[idx], (k <= 12) ? mem_sug[k - 1] : 1'b0);
                chk("pulse_wvalid", p_wv[idx], (k >= 7) ? 1 : 0);
                if (k >= 7) begin
                    chk("pulse_wx", p_wx[idx], (k - 7) % 4);
                    chk("pulse_wy", p_wy[idx], (k - 7) / 4);
                end
            end
        end
        if (pb + 17 < p_view.size()) begin
            chk("p7_x", p_wx[pb + 6], 0);
            chk("p10_x", p_wx[pb + 9], 3);
            chk("p10_y", p_wy[pb + 9], 0);
            chk("p18_x", p_wx[pb + 17], 3);
            chk("p18_y", p_wy[pb + 17], 2);
        end
        chk("done_pulses", fd_log.size() - fdb, 1);
        if (fd_log.size() > fdb) begin
            chk("done_at_pulse", fd_log[fdb] - pb, 18);
            chk("done_after_pulse", fd_prev[fdb], 1);
        end
        chk("no_back_to_back", b2b, 0);
        chk("addr_stable", unstable, 0);
    endtask

    task automatic pause_run(input string tag);
        int snap;
        RUN = 1'b0;
        @(posedge clk); #1;
        snap = p_view.size();
        repeat (4) @(posedge clk);
        #1;
        chk(tag, p_view.size() - snap, 0);
        RUN = 1'b1;
    endtask

    initial begin
        int pb, ab, fdb, n;
        RESET_SIM = 1'b1; RUN = 1'b0; frame_start = 1'b0;
        mem_rvalid = 1'b0; mem_rdata_signal = '0; mem_rdata_sugar = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pulse", newLocClock, 0);
        chk("rst_view", viewSignal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", writeLoc_valid, 0);
        chk("rst_state", dbg_state, 0);
        RESET_SIM = 1'b0;
        @(posedge clk); #1;

        // frame_start with RUN=0 is ignored
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("run0_start_busy", busy, 0);
        chk("run0_start_rd", mem_rd, 0);
        chk("run0_start_pulses", p_view.size(), 0);
        RUN = 1'b1;

        // Frame 1: zero-wait memory
        start_frame(pb, ab, fdb);
        wait_done(fdb);
        check_frame(pb, ab, fdb);

        // Frame 2: random latency plus frame_start while busy
        lat_rand = 1;
        start_frame(pb, ab, fdb);
        repeat (15) @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_done(fdb);
        check_frame(pb, ab, fdb);

        // Frame 3: RUN paused mid-READ and mid-EMIT
        start_frame(pb, ab, fdb);
        repeat (8) @(posedge clk);
        #1;
        n = 0;
        while (dbg_state != 3'd1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("reach_read", dbg_state, 1);
        pause_run("pause_read_pulses");
        n = 0;
        while (dbg_state != 3'd2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("reach_emit", dbg_state, 2);
        RUN = 1'b0;
        @(posedge clk); #1;
        n = p_view.size();
        repeat (4) @(posedge clk);
        #1;
        chk("pause_emit_pulses", p_view.size() - n, 0);
        chk("pause_emit_hold", dbg_state, 2);
        RUN = 1'b1;
        wait_done(fdb);
        check_frame(pb, ab, fdb);

        // Frame 4: asynchronous reset during pulse 9
        lat_rand = 0;
        start_frame(pb, ab, fdb);
        n = 0;
        while (p_view.size() - pb < 9 && n < 200) begin @(negedge clk); #1; n++; end
        chk("reach_pulse9", p_view.size() - pb, 9);
        #1;
        RESET_SIM = 1'b1;
        #1;
        chk("arst_pulse", newLocClock, 0);
        chk("arst_mem_rd", mem_rd, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_view", viewSignal, 0);
        chk("arst_sugar", viewSugar, 0);
        chk("arst_wx", writeLoc_X, 0);
        chk("arst_wy", writeLoc_Y, 0);
        chk("arst_valid", writeLoc_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", frame_done, 0);
        @(posedge clk);
        @(posedge clk); #1;
        RESET_SIM = 1'b0;
        @(posedge clk); #1;
        chk("arst_state", dbg_state, 0);

        // Frame 5: clean frame after reset
        start_frame(pb, ab, fdb);
        wait_done(fdb);
        check_frame(pb, ab, fdb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
